// File: rtl/emmc_dev_cmd_if.sv
// CMD line plus decoded-command and sideband request signals of the eMMC device CMD responder.
// slave = card-side responder, master = host model / data and busy engines.
interface emmc_dev_cmd_if;
  logic        emmc_cmd_i;
  logic        emmc_cmd_o;
  logic        emmc_cmd_oe_o;
  logic        cmd_valid_o;
  logic [5:0]  cmd_idx_o;
  logic [31:0] cmd_arg_o;
  logic        dat_rd_req_o;
  logic        dat_wr_req_o;
  logic        dat_ext_csd_o;
  logic [31:0] blk_addr_o;
  logic        busy_req_o;
  logic        illegal_o;
  logic        crc_err_o;
  logic [3:0]  card_state_o;

  modport slave (
    input  emmc_cmd_i,
    output emmc_cmd_o, emmc_cmd_oe_o, cmd_valid_o, cmd_idx_o, cmd_arg_o,
           dat_rd_req_o, dat_wr_req_o, dat_ext_csd_o, blk_addr_o,
           busy_req_o, illegal_o, crc_err_o, card_state_o
  );

  modport master (
    output emmc_cmd_i,
    input  emmc_cmd_o, emmc_cmd_oe_o, cmd_valid_o, cmd_idx_o, cmd_arg_o,
           dat_rd_req_o, dat_wr_req_o, dat_ext_csd_o, blk_addr_o,
           busy_req_o, illegal_o, crc_err_o, card_state_o
  );
endinterface

// File: rtl/emmc_dev_cmd.sv
// Device-side eMMC CMD-line responder: frame capture, card state tracking, R1/R2/R3 serialisation.
// Optional receive CRC7 checking is enabled by defining EMMC_DEV_CRC_CHECK_EN.
module emmc_dev_cmd #(
  parameter logic [127:0] CID         = {4'h7, 124'h0},
  parameter logic [127:0] CSD         = 128'h0,
  parameter logic [31:0]  OCR         = 32'h40FF8080,
  parameter int           READY_DELAY = 2,
  parameter int           NCR         = 2
) (
  input logic           clk_i,
  input logic           rst_i,
  emmc_dev_cmd_if.slave bus
);
  typedef enum logic [2:0] {RX_IDLE, RX_SHIFT, RX_CHECK, WAIT_NCR, TX, DONE} rx_state_e;
  typedef enum logic [3:0] {ST_IDLE = 4'd0, ST_READY = 4'd1, ST_IDENT = 4'd2,
                            ST_STBY = 4'd3, ST_TRAN = 4'd4} card_state_e;
  typedef enum logic [1:0] {RSP_NONE, RSP_R1, RSP_R2, RSP_R3} rsp_e;

  localparam logic [7:0] RDY    = 8'(READY_DELAY);
  localparam logic [6:0] NCR_LD = 7'(NCR - 2);

  // CRC7 (x^7+x^3+1, zero seed) over the low n bits of d, MSB first.
  function automatic logic [6:0] crc7(input logic [119:0] d, input int n);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 119; i >= 0; i--) begin
      if (i < n) begin
        fb = d[i] ^ c[6];
        c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
      end
    end
    return c;
  endfunction

  rx_state_e   r_state, w_state_nxt;
  card_state_e r_card, w_card_nxt;
  rsp_e        w_rsp;

  logic [47:0]  r_rx;
  logic [5:0]   r_rxcnt;
  logic [135:0] r_tx, w_tx_load;
  logic [7:0]   r_txcnt, w_tx_len;
  logic [6:0]   r_wait;
  logic [15:0]  r_rca;
  logic [7:0]   r_poll;
  logic         r_illegal;
  logic         r_pend_busy, r_pend_rd, r_pend_wr, r_pend_ext;
  logic         r_cmd_o, r_oe, r_valid, r_ill_p, r_busy, r_rd_req, r_wr_req, r_ext;
  logic [5:0]   r_idx;
  logic [31:0]  r_arg, r_blk;

  logic [5:0]   w_idx;
  logic [31:0]  w_arg, w_status;
  logic [39:0]  w_r1_body;
  logic [119:0] w_r2_body;
  logic         w_fmt_ok, w_crc_bad, w_accept, w_legal, w_rca_hit, w_ready;
  logic         w_clr, w_poll_inc, w_set_rca, w_r2_cid;
  logic         w_post_busy, w_post_rd, w_post_wr, w_post_ext, w_blk_ld;

`ifdef EMMC_DEV_CRC_CHECK_EN
  logic r_crc_err;
  assign w_crc_bad = w_fmt_ok && (crc7({80'd0, r_rx[47:8]}, 40) != r_rx[7:1]);
  always_ff @(posedge clk_i) begin
    if (rst_i) r_crc_err <= 1'b0;
    else       r_crc_err <= (r_state == RX_CHECK) && w_crc_bad;
  end
  assign bus.crc_err_o = r_crc_err;
`else
  assign w_crc_bad     = 1'b0;
  assign bus.crc_err_o = 1'b0;
`endif

  assign w_idx     = r_rx[45:40];
  assign w_arg     = r_rx[39:8];
  assign w_fmt_ok  = r_rx[46] & r_rx[0];
  assign w_accept  = w_fmt_ok & ~w_crc_bad;
  assign w_rca_hit = (w_arg[31:16] == r_rca);
  assign w_ready   = (r_poll >= RDY);

  // Command table: legality and side effects depend on the state before the command.
  always_comb begin
    w_legal     = 1'b0;
    w_rsp       = RSP_NONE;
    w_card_nxt  = r_card;
    w_clr       = 1'b0;
    w_poll_inc  = 1'b0;
    w_set_rca   = 1'b0;
    w_r2_cid    = 1'b0;
    w_post_busy = 1'b0;
    w_post_rd   = 1'b0;
    w_post_wr   = 1'b0;
    w_post_ext  = 1'b0;
    w_blk_ld    = 1'b0;
    case (w_idx)
      6'd0: begin
        w_legal = 1'b1; w_card_nxt = ST_IDLE; w_clr = 1'b1;
      end
      6'd1: if (r_card == ST_IDLE) begin
        w_legal = 1'b1; w_rsp = RSP_R3; w_poll_inc = 1'b1;
        if (w_ready) w_card_nxt = ST_READY;
      end
      6'd2: if (r_card == ST_READY) begin
        w_legal = 1'b1; w_rsp = RSP_R2; w_r2_cid = 1'b1; w_card_nxt = ST_IDENT;
      end
      6'd3: if (r_card == ST_IDENT) begin
        w_legal = 1'b1; w_rsp = RSP_R1; w_set_rca = 1'b1; w_card_nxt = ST_STBY;
      end
      6'd9: if (r_card == ST_STBY && w_rca_hit) begin
        w_legal = 1'b1; w_rsp = RSP_R2;
      end
      6'd7: begin
        if (r_card == ST_STBY && w_rca_hit) begin
          w_legal = 1'b1; w_rsp = RSP_R1; w_post_busy = 1'b1; w_card_nxt = ST_TRAN;
        end else if (r_card == ST_TRAN && !w_rca_hit) begin
          w_legal = 1'b1; w_card_nxt = ST_STBY;
        end
      end
      6'd6: if (r_card == ST_TRAN) begin
        w_legal = 1'b1; w_rsp = RSP_R1; w_post_busy = 1'b1;
      end
      6'd8: if (r_card == ST_TRAN) begin
        w_legal = 1'b1; w_rsp = RSP_R1; w_post_rd = 1'b1; w_post_ext = 1'b1;
      end
      6'd17: if (r_card == ST_TRAN) begin
        w_legal = 1'b1; w_rsp = RSP_R1; w_post_rd = 1'b1; w_blk_ld = 1'b1;
      end
      6'd24: if (r_card == ST_TRAN) begin
        w_legal = 1'b1; w_rsp = RSP_R1; w_post_wr = 1'b1; w_blk_ld = 1'b1;
      end
      default: ;
    endcase
  end

  // Response image, left-aligned in a 136-bit shifter.
  always_comb begin
    w_status  = {9'd0, r_illegal, 9'd0, r_card, 1'b1, 8'd0};
    w_r1_body = {2'b00, w_idx, w_status};
    w_r2_body = w_r2_cid ? CID[127:8] : CSD[127:8];
    case (w_rsp)
      RSP_R1:  w_tx_load = {w_r1_body, crc7({80'd0, w_r1_body}, 40), 1'b1, 88'd0};
      RSP_R2:  w_tx_load = {2'b00, 6'h3F, w_r2_body, crc7(w_r2_body, 120), 1'b1};
      RSP_R3:  w_tx_load = {2'b00, 6'h3F, w_ready, OCR[30:0], 7'h7F, 1'b1, 88'd0};
      default: w_tx_load = '1;
    endcase
    w_tx_len = (w_rsp == RSP_R2) ? 8'd135 : 8'd47;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= RX_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RX_IDLE, DONE: w_state_nxt = bus.emmc_cmd_i ? RX_IDLE : RX_SHIFT;
      RX_SHIFT:      if (r_rxcnt == 6'd47) w_state_nxt = RX_CHECK;
      RX_CHECK:      w_state_nxt = (w_accept && w_rsp != RSP_NONE) ? WAIT_NCR : RX_IDLE;
      WAIT_NCR:      if (r_wait == '0) w_state_nxt = TX;
      TX:            if (r_txcnt == '0) w_state_nxt = DONE;
      default:       w_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rx <= '0; r_rxcnt <= '0; r_tx <= '0; r_txcnt <= '0; r_wait <= '0;
      r_card <= ST_IDLE; r_rca <= '0; r_poll <= '0; r_illegal <= 1'b0;
      r_pend_busy <= 1'b0; r_pend_rd <= 1'b0; r_pend_wr <= 1'b0; r_pend_ext <= 1'b0;
      r_cmd_o <= 1'b1; r_oe <= 1'b0; r_valid <= 1'b0; r_ill_p <= 1'b0;
      r_busy <= 1'b0; r_rd_req <= 1'b0; r_wr_req <= 1'b0; r_ext <= 1'b0;
      r_idx <= '0; r_arg <= '0; r_blk <= '0;
    end else begin
      r_valid  <= 1'b0;
      r_ill_p  <= 1'b0;
      r_busy   <= 1'b0;
      r_rd_req <= 1'b0;
      r_wr_req <= 1'b0;
      r_ext    <= 1'b0;
      case (r_state)
        RX_IDLE, DONE: if (!bus.emmc_cmd_i) begin
          r_rx    <= '0;
          r_rxcnt <= 6'd1;
        end
        RX_SHIFT: begin
          r_rx    <= {r_rx[46:0], bus.emmc_cmd_i};
          r_rxcnt <= r_rxcnt + 6'd1;
        end
        RX_CHECK: if (w_accept) begin
          r_valid <= 1'b1;
          r_idx   <= w_idx;
          r_arg   <= w_arg;
          r_card  <= w_card_nxt;
          r_ill_p <= ~w_legal;
          if (!w_legal)              r_illegal <= 1'b1;
          else if (w_rsp == RSP_R1)  r_illegal <= 1'b0;
          if (w_clr) begin
            r_poll <= '0;
            r_rca  <= '0;
          end
          if (w_poll_inc && r_poll != RDY) r_poll <= r_poll + 8'd1;
          if (w_set_rca) r_rca <= w_arg[31:16];
          if (w_blk_ld)  r_blk <= w_arg;
          r_pend_busy <= w_post_busy;
          r_pend_rd   <= w_post_rd;
          r_pend_wr   <= w_post_wr;
          r_pend_ext  <= w_post_ext;
          r_tx        <= w_tx_load;
          r_txcnt     <= w_tx_len;
          r_wait      <= NCR_LD;
        end
        WAIT_NCR: begin
          if (r_wait == '0) begin
            r_oe    <= 1'b1;
            r_cmd_o <= r_tx[135];
            r_tx    <= {r_tx[134:0], 1'b1};
          end else begin
            r_wait <= r_wait - 7'd1;
          end
        end
        TX: begin
          if (r_txcnt != '0) begin
            r_cmd_o <= r_tx[135];
            r_tx    <= {r_tx[134:0], 1'b1};
            r_txcnt <= r_txcnt - 8'd1;
          end else begin
            // End bit has been on the line a full cycle: release CMD, fire follow-on requests.
            r_oe     <= 1'b0;
            r_cmd_o  <= 1'b1;
            r_busy   <= r_pend_busy;
            r_rd_req <= r_pend_rd;
            r_wr_req <= r_pend_wr;
            r_ext    <= r_pend_ext;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.emmc_cmd_o    = r_cmd_o;
  assign bus.emmc_cmd_oe_o = r_oe;
  assign bus.cmd_valid_o   = r_valid;
  assign bus.cmd_idx_o     = r_idx;
  assign bus.cmd_arg_o     = r_arg;
  assign bus.dat_rd_req_o  = r_rd_req;
  assign bus.dat_wr_req_o  = r_wr_req;
  assign bus.dat_ext_csd_o = r_ext;
  assign bus.blk_addr_o    = r_blk;
  assign bus.busy_req_o    = r_busy;
  assign bus.illegal_o     = r_ill_p;
  assign bus.card_state_o  = r_card;
endmodule

// File: doc/emmc_dev_cmd.md
# emmc_dev_cmd

Device-side eMMC CMD-line responder, the card end of the host command sequencer. Deserialises 48-bit host command frames from the CMD line and checks CRC7. Tracks the card state (idle/ready/ident/stby/tran) and serialises R1/R2/R3 responses. Raises one-cycle requests to a separate device data engine for CMD8/17/24 and to a busy generator for R1b commands. Used as a synthesizable card model for host bring-up and in loopback benches.

## Interface

Parameters:
- `CID`, 128'h7000…0, card CID; bits [7:1] replaced by computed CRC7 on transmit.
- `CSD`, 128'h0, card CSD; same CRC rule.
- `OCR`, 32'h40FF8080, OCR; bit 31 is overridden by the ready logic.
- `READY_DELAY`, 2, number of CMD1 responses sent with OCR[31]=0 before ready.
- `NCR`, 2, cycles from sampled end bit to response start bit; legal range 2..64.

Ports:
- `clk_i` in 1: clock; CMD sampled and driven on rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `emmc_cmd_i` in 1: CMD line from host; idles high.
- `emmc_cmd_o` out 1: response bit.
- `emmc_cmd_oe_o` out 1: CMD output enable.
- `cmd_valid_o` out 1: pulse, accepted frame.
- `cmd_idx_o` out 6: index of the accepted frame.
- `cmd_arg_o` out 32: argument of the accepted frame.
- `dat_rd_req_o` out 1: pulse, device-to-host block transfer.
- `dat_wr_req_o` out 1: pulse, host-to-device block transfer.
- `dat_ext_csd_o` out 1: qualifies `dat_rd_req_o` as an EXT_CSD read.
- `blk_addr_o` out 32: block address for the data request.
- `busy_req_o` out 1: pulse, R1b busy to be driven on DAT0.
- `illegal_o` out 1: pulse, command illegal in the current state.
- `crc_err_o` out 1: pulse, CRC7 mismatch (see Configuration).
- `card_state_o` out 4: 0 idle, 1 ready, 2 ident, 3 stby, 4 tran.

## Operation

- **RX FSM states:** RX_IDLE, RX_SHIFT, RX_CHECK, WAIT_NCR, TX, DONE.
- **Frame detection:** In RX_IDLE, a 0 on `emmc_cmd_i` is the start bit. Shift 48 bits MSB first.
  - Transmission bit (bit 46) must be 1.
  - End bit must be 1.
  - Any violation drops the frame silently and returns to RX_IDLE.
- **CRC7:** Polynomial x^7+x^3+1, initial value 0, computed over bits [47:8].
- **Accepted frame:**
  - `cmd_valid_o` pulses and the card state updates.
  - If a response is due, go to WAIT_NCR, then TX. Otherwise go back to RX_IDLE.
- **Command table (anything else → `illegal_o`, no response):**
  - **CMD0, any state:** go to idle, clear the CMD1 poll counter, RCA = 0, no response.
  - **CMD1, idle:**
    - Respond R3 with OCR[31] = (poll count ≥ READY_DELAY).
    - The counter increments each CMD1, saturating.
    - When bit 31 is sent as 1, go to ready.
  - **CMD2, ready:** R2 with CID, go to ident.
  - **CMD3, ident:** RCA = arg[31:16], R1, go to stby.
  - **CMD9, stby, arg[31:16]==RCA:** R2 with CSD.
  - **CMD7:**
    - In stby with RCA match: R1, then `busy_req_o`, go to tran.
    - In tran with RCA mismatch: go to stby, no response.
  - **CMD6, tran:** R1, then `busy_req_o`.
  - **CMD8, tran:** R1, then `dat_rd_req_o` with `dat_ext_csd_o`=1.
  - **CMD17, tran:** R1, then `dat_rd_req_o` with `blk_addr_o`=arg.
  - **CMD24, tran:** R1, then `dat_wr_req_o` with `blk_addr_o`=arg.
- **Response formats:**
  - **R1 (48 bits):** 0, 0, idx, status, CRC7, 1.
    - status[22] = illegal flag, set by the previous illegal command and cleared once reported.
    - status[12:9] = state before the command.
    - status[8] = 1; all other bits 0.
  - **R3 (48 bits):** 0, 0, 6'h3F, OCR, 7'h7F, 1.
  - **R2 (136 bits):** 0, 0, 6'h3F, reg[127:8], CRC7(reg[127:8]), 1.
- **Receiver during transmit:** ignores `emmc_cmd_i` from the sampled end bit until TX completes.

## Timing

- **Reset values:**
  - `emmc_cmd_o`=1, `emmc_cmd_oe_o`=0, `card_state_o`=0.
  - RCA, poll counter, illegal flag all 0.
  - All pulses 0, `cmd_idx_o`/`cmd_arg_o`/`blk_addr_o`=0.
- **Decode (end bit sampled at cycle T):**
  - `cmd_valid_o`, `cmd_idx_o`, `cmd_arg_o` valid at T+1; data/arg outputs hold until the next accepted frame.
  - `card_state_o` updates at T+1.
  - `illegal_o` and `crc_err_o` pulse at T+1.
- **Response drive:**
  - `emmc_cmd_oe_o` rises at T+NCR with the start bit.
  - Stays high for exactly 48 (R1/R3) or 136 (R2) cycles, falling the cycle after the end bit.
  - `emmc_cmd_o` returns to 1 when not driving.
- **Post-response pulses:** `dat_*_req_o` and `busy_req_o` pulse one cycle, the cycle after the end bit (oe falling edge).
- **Re-arm:** receiver is ready at T+1 for no-response frames, and at the oe falling edge otherwise.
- **Reset mid-operation:**
  - `rst_i` high at any cycle returns everything to reset values at the next edge.
  - A partially transmitted response is abandoned.
- **Start bit during WAIT_NCR/TX:** ignored.

## Configuration

- `EMMC_DEV_CRC_CHECK_EN`:
  - **Defined:** a CRC7 mismatch drops the frame, pulses `crc_err_o` at T+1, and leaves the state unchanged.
  - **Undefined:** the received CRC field is ignored, `crc_err_o` is tied 0, and the checker logic is removed.
  - Transmit CRC generation is always present.

## Test plan

- **CMD0 after reset:** reset, then CMD0 arg 0 → `cmd_valid_o` at T+1, `emmc_cmd_oe_o` stays 0, `card_state_o`=0.
- **CMD1 polling (READY_DELAY=2):** send CMD1 arg 32'h40FF8080 three times.
  - Responses 1–2 are R3 with OCR 32'h40FF8080.
  - Response 3 is R3 with 32'hC0FF8080, and state = 1.
  - oe rises at T+2.
- **CMD2 then CMD3:**
  - CMD2 → 136-bit R2 whose CRC7 matches CID[127:8]; state = 2.
  - CMD3 arg 32'h00040000 → R1, idx 3, status[12:9]=2; state = 3.
- **CMD7 then CMD17:**
  - CMD7 arg 32'h00040000 → R1, `busy_req_o` pulse after the end bit, state = 4.
  - CMD17 arg 32'h100 → R1 idx 17, `dat_rd_req_o` pulse with `blk_addr_o`=32'h100.
- **Bad CRC and illegal command (macro defined):**
  - CMD9 with one CRC bit flipped → `crc_err_o` pulse, no response.
  - CMD2 in tran → `illegal_o`; the next R1 has status[22]=1.
- **Reset mid-R2:** assert `rst_i` at the 60th R2 bit → oe=0, `emmc_cmd_o`=1, `card_state_o`=0 on the next edge.
